// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg
//   Shared types and helpers for the piso_stream slice.
//   state_t   : IDLE (no active load) / SHIFT (slot 0 presented on the serial side)
//   clamp_len : maps a requested word count onto the effective count 1..ndata.
//               Zero or over-range requests mean "all words".
package piso_stream_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned ndata);
      return (len == 0 || len > ndata) ? ndata : len;
   endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// piso_hold_reg
//   One-entry holding register (parallel data + effective length) with a
//   valid flag. It lets the producer queue its next load while the current
//   one is still shifting out.
//   i_clk    clock
//   i_clear  synchronous clear, drops the held entry
//   i_load   capture i_data/i_len (only issued while empty)
//   i_take   consume the held entry (only issued while full)
//   i_data   parallel words to hold
//   i_len    effective (already clamped) word count
//   o_full   an entry is held
//   o_data   held words
//   o_len    held word count
module piso_hold_reg #(
   parameter int unsigned BIT   = 8,
   parameter int unsigned NDATA = 4,
   parameter int unsigned LENW  = $clog2(NDATA + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_clear,
   input  logic                 i_load,
   input  logic                 i_take,
   input  logic [BIT*NDATA-1:0] i_data,
   input  logic [LENW-1:0]      i_len,
   output logic                 o_full,
   output logic [BIT*NDATA-1:0] o_data,
   output logic [LENW-1:0]      o_len
);

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         o_full <= 1'b0;
         o_data <= '0;
         o_len  <= '0;
      end else if (i_load) begin
         o_full <= 1'b1;
         o_data <= i_data;
         o_len  <= i_len;
      end else if (i_take) begin
         o_full <= 1'b0;
      end
   end

endmodule

// File: rtl/piso_stream.sv
// piso_stream
//   Parallel-in / serial-out with valid/ready on both sides. A load captures
//   up to NDATA words plus a word count; words 0..len-1 are then emitted one
//   per accepted output beat, with o_last on the final one.
//   Optional feature macro: PISO_STREAM_DBUF_EN adds a one-entry holding
//   register so back-to-back loads stream without a bubble.
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_data   parallel words, word k = i_data[k*BIT +: BIT], word 0 first
//   i_len    words to emit (0 or >NDATA means NDATA)
//   i_valid  load request
//   o_ready  load accepted this cycle when i_valid is high
//   o_data   current serial word (slot 0)
//   o_valid  o_data valid
//   o_last   o_data is the final word of its load
//   i_ready  consumer accepts o_data
//   o_cnt    words left in the active load, current one included
module piso_stream
   import piso_stream_pkg::*;
#(
   parameter int unsigned    BIT   = 8,
   parameter int unsigned    NDATA = 4,
   parameter logic [BIT-1:0] TAIL  = '0,
   parameter int unsigned    LENW  = $clog2(NDATA + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [BIT*NDATA-1:0] i_data,
   input  logic [LENW-1:0]      i_len,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic [BIT-1:0]       o_data,
   output logic                 o_valid,
   output logic                 o_last,
   input  logic                 i_ready,
   output logic [LENW-1:0]      o_cnt
);

   state_t                         state, state_n;
   logic [NDATA-1:0][BIT-1:0]      slots, slots_n;
   logic [LENW-1:0]                cnt, cnt_n;

   logic                           fire_ld, fire_out, last_beat;
   logic                           ld_slots;
   logic [BIT*NDATA-1:0]           ld_data;
   logic [LENW-1:0]                ld_len;
   logic [LENW-1:0]                in_len;

   assign in_len    = LENW'(clamp_len(32'(i_len), NDATA));
   assign fire_ld   = i_valid && o_ready;
   assign fire_out  = o_valid && i_ready;
   assign last_beat = fire_out && (cnt == LENW'(1));

`ifdef PISO_STREAM_DBUF_EN
   logic                 hold_full, hold_load, hold_take;
   logic [BIT*NDATA-1:0] hold_data;
   logic [LENW-1:0]      hold_len;

   assign o_ready   = !hold_full;
   // A load during SHIFT parks in the holding register, except on the final
   // beat with the holder empty: then it goes straight into the slots.
   assign hold_load = fire_ld && (state == SHIFT) && !last_beat;
   assign hold_take = last_beat && hold_full;

   piso_hold_reg #(
      .BIT   (BIT),
      .NDATA (NDATA),
      .LENW  (LENW)
   ) u_hold (
      .i_clk   (i_clk),
      .i_clear (i_rst),
      .i_load  (hold_load),
      .i_take  (hold_take),
      .i_data  (i_data),
      .i_len   (in_len),
      .o_full  (hold_full),
      .o_data  (hold_data),
      .o_len   (hold_len)
   );
`else
   assign o_ready = (state == IDLE);
`endif

   always_comb begin
      state_n  = state;
      slots_n  = slots;
      cnt_n    = cnt;
      ld_slots = 1'b0;
      ld_data  = i_data;
      ld_len   = in_len;
      case (state)
         IDLE: begin
            if (fire_ld) begin
               ld_slots = 1'b1;
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            if (last_beat) begin
               for (int i = 0; i < NDATA; i++) slots_n[i] = TAIL;
               cnt_n   = '0;
               state_n = IDLE;
`ifdef PISO_STREAM_DBUF_EN
               if (hold_full) begin
                  ld_slots = 1'b1;
                  ld_data  = hold_data;
                  ld_len   = hold_len;
                  state_n  = SHIFT;
               end else if (fire_ld) begin
                  ld_slots = 1'b1;
                  state_n  = SHIFT;
               end
`endif
            end else if (fire_out) begin
               for (int i = 0; i < NDATA - 1; i++) slots_n[i] = slots[i+1];
               slots_n[NDATA-1] = TAIL;
               cnt_n = cnt - LENW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if (ld_slots) begin
         for (int k = 0; k < NDATA; k++) slots_n[k] = ld_data[k*BIT +: BIT];
         cnt_n = ld_len;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
         for (int i = 0; i < NDATA; i++) slots[i] <= TAIL;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         slots <= slots_n;
      end
   end

   // All serial-side outputs decode from registers only.
   assign o_valid = (state == SHIFT);
   assign o_data  = slots[0];
   assign o_last  = (state == SHIFT) && (cnt == LENW'(1));
   assign o_cnt   = cnt;

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;
   localparam int unsigned    BIT   = 8;
   localparam int unsigned    NDATA = 4;
   localparam int unsigned    LENW  = $clog2(NDATA + 1);
   localparam logic [BIT-1:0] TAIL  = 8'h5A;

   logic                 i_clk = 1'b0;
   logic                 i_rst;
   logic [BIT*NDATA-1:0] i_data;
   logic [LENW-1:0]      i_len;
   logic                 i_valid;
   logic                 o_ready;
   logic [BIT-1:0]       o_data;
   logic                 o_valid;
   logic                 o_last;
   logic                 i_ready;
   logic [LENW-1:0]      o_cnt;

   piso_stream #(.BIT(BIT), .NDATA(NDATA), .TAIL(TAIL)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_data  (i_data),
      .i_len   (i_len),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_last  (o_last),
      .i_ready (i_ready),
      .o_cnt   (o_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Reference: a queue of every word still owed to the consumer, in order,
   // each tagged with its last flag and remaining-count of its own load.
   typedef struct {
      logic [BIT-1:0] w;
      bit             last;
      int             cnt;
   } beat_t;

   beat_t q[$];
   int    errors = 0;
   int    checks = 0;
   string phase  = "reset";

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, got, exp);
      end
   endtask

   function automatic int nloads();
      int n = 0;
      foreach (q[i]) if (q[i].last) n++;
      return n;
   endfunction

   // Loads that the block can still accept: one in flight at most without
   // double buffering, one active plus one held with it.
   function automatic bit exp_ready();
`ifdef PISO_STREAM_DBUF_EN
      return nloads() < 2;
`else
      return q.size() == 0;
`endif
   endfunction

   task automatic push_load(input logic [BIT*NDATA-1:0] d, input logic [LENW-1:0] len);
      int   l;
      beat_t b;
      l = (len == 0 || len > NDATA) ? NDATA : int'(len);
      for (int k = 0; k < l; k++) begin
         b.w    = d[k*BIT +: BIT];
         b.last = (k == l - 1);
         b.cnt  = l - k;
         q.push_back(b);
      end
   endtask

   // One clock: check outputs mid-cycle, then advance the model on the edge.
   task automatic cycle();
      bit fl, fo;
      @(negedge i_clk);
      chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
      chk("o_ready", 32'(o_ready), 32'(exp_ready()));
      if (q.size() != 0) begin
         chk("o_data", 32'(o_data), 32'(q[0].w));
         chk("o_last", 32'(o_last), 32'(q[0].last));
         chk("o_cnt",  32'(o_cnt),  32'(q[0].cnt));
      end else begin
         chk("o_data", 32'(o_data), 32'(TAIL));
         chk("o_last", 32'(o_last), 32'(0));
         chk("o_cnt",  32'(o_cnt),  32'(0));
      end
      fl = i_valid && exp_ready();
      fo = (q.size() != 0) && i_ready;
      @(posedge i_clk);
      if (i_rst) q.delete();
      else begin
         if (fo) void'(q.pop_front());
         if (fl) push_load(i_data, i_len);
      end
      #1;
   endtask

   initial begin
      bit acc;
      i_rst = 1'b1; i_data = '0; i_len = '0; i_valid = 1'b0; i_ready = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      cycle();

      phase = "len4";
      i_data = 32'h44332211; i_len = 3'd4; i_valid = 1'b1;
      cycle();
      i_valid = 1'b0;
      repeat (6) cycle();

      phase = "len2";
      i_len = 3'd2; i_valid = 1'b1;
      cycle();
      i_valid = 1'b0;
      repeat (4) cycle();

      phase = "len0";
      i_len = 3'd0; i_valid = 1'b1;
      cycle();
      i_valid = 1'b0;
      repeat (6) cycle();

      phase = "backpressure";
      i_len = 3'd4; i_valid = 1'b1;
      cycle();
      i_valid = 1'b0; i_ready = 1'b0;
      repeat (3) cycle();
      i_ready = 1'b1;
      repeat (6) cycle();

      phase = "midreset";
      i_valid = 1'b1;
      cycle();
      i_valid = 1'b0;
      cycle();
      i_rst = 1'b1;
      cycle();
      i_rst = 1'b0;
      cycle();
      i_data = 32'hDDCCBBAA; i_len = 3'd4; i_valid = 1'b1;
      cycle();
      i_valid = 1'b0;
      repeat (6) cycle();

      phase = "b2b_len3";
      i_data = 32'h00332211; i_len = 3'd3; i_valid = 1'b1;
      cycle();
      i_data = 32'h00665544;
      for (int n = 0; n < 10; n++) begin
         acc = exp_ready();
         cycle();
         if (acc) break;
      end
      i_valid = 1'b0;
      repeat (8) cycle();

      phase = "valid_held";
      i_data = 32'h87654321; i_len = 3'd2; i_valid = 1'b1;
      repeat (12) cycle();
      i_valid = 1'b0;
      repeat (6) cycle();

      phase = "random";
      for (int n = 0; n < 500; n++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 3) != 0);
         i_len   = LENW'($urandom_range(0, 7));
         i_data  = $urandom;
         i_rst   = ($urandom_range(0, 99) == 0);
         cycle();
      end
      i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      repeat (10) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
